// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_parser: decodes UART command frames (WR/RD/ALU), drives the     |
// | register-file and ALU strobes and queues response bytes for transmit.    |
// | Optional CMD_ERR_DROP_EN: abort the frame on a flagged receive byte.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_cmd_parser #(
    parameter int D_WIDTH = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [D_WIDTH-1:0]     rx_data,
    input  logic                   rx_valid,
    input  logic                   parity_error,
    input  logic                   framing_error,
    input  logic [D_WIDTH-1:0]     rf_rd_data,
    input  logic                   rf_rd_valid,
    input  logic [2*D_WIDTH-1:0]   alu_out,
    input  logic                   alu_out_valid,
    input  logic                   tx_fifo_full,
    output logic                   rf_wr_en,
    output logic                   rf_rd_en,
    output logic [ADDR_W-1:0]      rf_addr,
    output logic [D_WIDTH-1:0]     rf_wr_data,
    output logic                   alu_en,
    output logic [3:0]             alu_fun,
    output logic                   clk_gate_en,
    output logic [D_WIDTH-1:0]     tx_data,
    output logic                   tx_valid,
    output logic                   cmd_err
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_ADDR  = 4'd1;
    localparam logic [3:0] c_WR_DATA  = 4'd2;
    localparam logic [3:0] c_RD_ADDR  = 4'd3;
    localparam logic [3:0] c_RD_WAIT  = 4'd4;
    localparam logic [3:0] c_ALU_A    = 4'd5;
    localparam logic [3:0] c_ALU_B    = 4'd6;
    localparam logic [3:0] c_ALU_FUN  = 4'd7;
    localparam logic [3:0] c_ALU_WAIT = 4'd8;
    localparam logic [3:0] c_TX_SEND  = 4'd9;

    localparam logic [D_WIDTH-1:0] c_CMD_WR      = D_WIDTH'(8'hAA);
    localparam logic [D_WIDTH-1:0] c_CMD_RD      = D_WIDTH'(8'hBB);
    localparam logic [D_WIDTH-1:0] c_CMD_ALU_OP  = D_WIDTH'(8'hCC);
    localparam logic [D_WIDTH-1:0] c_CMD_ALU_NOP = D_WIDTH'(8'hDD);

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic                 w_err_abort;
    logic                 r_rf_wr_en;
    logic                 r_rf_rd_en;
    logic [ADDR_W-1:0]    r_rf_addr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [D_WIDTH-1:0]   r_rf_wr_data;
    logic                 r_alu_en;
    logic [3:0]           r_alu_fun;
    logic                 r_clk_gate_en;
    logic [D_WIDTH-1:0]   r_tx_data;
    logic                 r_tx_valid;
    logic                 r_cmd_err;
    logic [2*D_WIDTH-1:0] r_resp;
    logic                 r_tx_idx;
    logic                 r_tx_last;

`ifdef CMD_ERR_DROP_EN
    logic w_rx_state;

    always_comb begin
        w_rx_state = (r_state == c_IDLE)    || (r_state == c_WR_ADDR) ||
                     (r_state == c_WR_DATA) || (r_state == c_RD_ADDR) ||
                     (r_state == c_ALU_A)   || (r_state == c_ALU_B)   ||
                     (r_state == c_ALU_FUN);
    end

    assign w_err_abort = rx_valid & (parity_error | framing_error) & w_rx_state;
`else
    logic w_unused_err;

    assign w_unused_err = parity_error ^ framing_error;
    assign w_err_abort  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        if (w_err_abort) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            c_CMD_WR:      w_next_state = c_WR_ADDR;
                            c_CMD_RD:      w_next_state = c_RD_ADDR;
                            c_CMD_ALU_OP:  w_next_state = c_ALU_A;
                            c_CMD_ALU_NOP: w_next_state = c_ALU_FUN;
                            default:       w_next_state = c_IDLE;
                        endcase
                    end
                end
                c_WR_ADDR:  if (rx_valid) w_next_state = c_WR_DATA;
                c_WR_DATA:  if (rx_valid) w_next_state = c_IDLE;
                c_RD_ADDR:  if (rx_valid) w_next_state = c_RD_WAIT;
                c_RD_WAIT:  if (rf_rd_valid) w_next_state = c_TX_SEND;
                c_ALU_A:    if (rx_valid) w_next_state = c_ALU_B;
                c_ALU_B:    if (rx_valid) w_next_state = c_ALU_FUN;
                c_ALU_FUN:  if (rx_valid) w_next_state = c_ALU_WAIT;
                c_ALU_WAIT: if (alu_out_valid) w_next_state = c_TX_SEND;
                c_TX_SEND:  if (!tx_fifo_full && (r_tx_idx == r_tx_last)) w_next_state = c_IDLE;
                default:    w_next_state = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_addr     <= '0;
            r_wr_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= 4'd0;
            r_clk_gate_en <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_resp        <= '0;
            r_tx_idx      <= 1'b0;
            r_tx_last     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_alu_en      <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_cmd_err     <= w_err_abort;
            // Registered from the next state so the gate tracks ALU_FUN/ALU_WAIT exactly.
            r_clk_gate_en <= (w_next_state == c_ALU_FUN) || (w_next_state == c_ALU_WAIT);
            if (!w_err_abort) begin
                case (r_state)
                    c_WR_ADDR: if (rx_valid) r_wr_addr <= rx_data[ADDR_W-1:0];
                    c_WR_DATA: begin
                        if (rx_valid) begin
                            r_rf_wr_en   <= 1'b1;
                            r_rf_addr    <= r_wr_addr;
                            r_rf_wr_data <= rx_data;
                        end
                    end
                    c_RD_ADDR: begin
                        if (rx_valid) begin
                            r_rf_rd_en <= 1'b1;
                            r_rf_addr  <= rx_data[ADDR_W-1:0];
                        end
                    end
                    c_RD_WAIT: begin
                        if (rf_rd_valid) begin
                            r_resp    <= {{D_WIDTH{1'b0}}, rf_rd_data};
                            r_tx_idx  <= 1'b0;
                            r_tx_last <= 1'b0;
                        end
                    end
                    c_ALU_A: begin
                        if (rx_valid) begin
                            r_rf_wr_en   <= 1'b1;
                            r_rf_addr    <= '0;
                            r_rf_wr_data <= rx_data;
                        end
                    end
                    c_ALU_B: begin
                        if (rx_valid) begin
                            r_rf_wr_en   <= 1'b1;
                            r_rf_addr    <= ADDR_W'(1);
                            r_rf_wr_data <= rx_data;
                        end
                    end
                    c_ALU_FUN: begin
                        if (rx_valid) begin
                            r_alu_en  <= 1'b1;
                            r_alu_fun <= rx_data[3:0];
                        end
                    end
                    c_ALU_WAIT: begin
                        if (alu_out_valid) begin
                            r_resp    <= alu_out;
                            r_tx_idx  <= 1'b0;
                            r_tx_last <= 1'b1;
                        end
                    end
                    c_TX_SEND: begin
                        if (!tx_fifo_full) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= r_tx_idx ? r_resp[2*D_WIDTH-1:D_WIDTH] : r_resp[D_WIDTH-1:0];
                            r_tx_idx   <= r_tx_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rf_wr_en    = r_rf_wr_en;
    assign rf_rd_en    = r_rf_rd_en;
    assign rf_addr     = r_rf_addr;
    assign rf_wr_data  = r_rf_wr_data;
    assign alu_en      = r_alu_en;
    assign alu_fun     = r_alu_fun;
    assign clk_gate_en = r_clk_gate_en;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_cmd_parser: frame-level model with expected-event queue plus     |
// | directed literal checks; honours CMD_ERR_DROP_EN like the design.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_parser;
    localparam int D_WIDTH = 8;
    localparam int ADDR_W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        parity_error = 1'b0;
    logic        framing_error = 1'b0;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        tx_fifo_full = 1'b0;
    logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid, cmd_err;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, tx_data;

    always #5 clk = ~clk;

    uart_cmd_parser #(.D_WIDTH(D_WIDTH), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .framing_error(framing_error),
        .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid), .tx_fifo_full(tx_fifo_full),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
        .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err)
    );

    typedef enum int {EV_WR, EV_RD, EV_ALU, EV_ERR, EV_GON, EV_GOFF} ev_kind_t;
    typedef struct {
        int       cyc;
        ev_kind_t kind;
        int       a;
        int       b;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] txq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         rand_full = 1'b0;
    bit         gate_on = 1'b0;
    logic       full_s = 1'b0;
    logic [3:0] h_addr = '0;
    logic [7:0] h_wdata = '0;
    logic [3:0] h_fun = '0;
    logic [7:0] h_tx = '0;
    bit         exp_gate = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_s <= tx_fifo_full;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at cycle %0d", name, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic void push(input int c, input ev_kind_t k, input int a, input int b);
        ev_t e;
        e.cyc = c; e.kind = k; e.a = a; e.b = b;
        evq.push_back(e);
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
        return b;
    endfunction

    // Per-cycle comparison of every output against the expected-event stream.
    always @(negedge clk) begin : p_cmp
        ev_t        ev;
        bit         e_wr, e_rd, e_alu, e_err;
        logic [3:0] e_addr, e_fun;
        logic [7:0] e_data;
        if (rst) begin
            e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
            e_addr = '0; e_fun = '0; e_data = '0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (ev.cyc < cyc) chk("stale_event", ev.cyc, cyc);
                case (ev.kind)
                    EV_WR:   begin e_wr = 1; e_addr = 4'(ev.a); e_data = 8'(ev.b); end
                    EV_RD:   begin e_rd = 1; e_addr = 4'(ev.a); end
                    EV_ALU:  begin e_alu = 1; e_fun = 4'(ev.a); end
                    EV_ERR:  e_err = 1;
                    EV_GON:  exp_gate = 1;
                    EV_GOFF: exp_gate = 0;
                    default: ;
                endcase
            end
            if (e_wr || e_rd) h_addr = e_addr;
            if (e_wr) h_wdata = e_data;
            if (e_alu) h_fun = e_fun;
            chk("rf_wr_en", rf_wr_en, e_wr);
            chk("rf_rd_en", rf_rd_en, e_rd);
            chk("rf_addr", rf_addr, h_addr);
            chk("rf_wr_data", rf_wr_data, h_wdata);
            chk("alu_en", alu_en, e_alu);
            chk("alu_fun", alu_fun, h_fun);
            chk("cmd_err", cmd_err, e_err);
            chk("clk_gate_en", clk_gate_en, exp_gate);
            if (tx_valid) begin
                chk("tx_while_full", full_s, 0);
                if (txq.size() == 0) chk("tx_unexpected", tx_valid, 0);
                else h_tx = txq.pop_front();
            end
            chk("tx_data", tx_data, h_tx);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        rx_valid = 0; parity_error = 0; framing_error = 0;
        rf_rd_valid = 0; alu_out_valid = 0;
        rx_data = 8'($urandom); rf_rd_data = 8'($urandom); alu_out = 16'($urandom);
        tx_fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    // em: 0 clean, 1 random gaps/errors, 2 forced parity error
    task automatic send_byte(input logic [7:0] b, input int em, output bit aborted);
        if (em == 1 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                step();
                rf_rd_valid   = ($urandom_range(0, 3) == 0);
                alu_out_valid = ($urandom_range(0, 3) == 0);
            end
        end
        step();
        rx_valid = 1;
        rx_data  = b;
        if (em == 2) parity_error = 1;
        else if (em == 1 && $urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 1) == 1) parity_error = 1;
            else framing_error = 1;
        end
        aborted = 0;
`ifdef CMD_ERR_DROP_EN
        if (parity_error || framing_error) begin
            aborted = 1;
            push(cyc + 1, EV_ERR, 0, 0);
            if (gate_on) begin
                gate_on = 0;
                push(cyc + 1, EV_GOFF, 0, 0);
            end
        end
`endif
    endtask

    // mode 1: read wait, 2: ALU wait, 3: transmitting
    task automatic wait_junk(input int mode);
        step();
        if ($urandom_range(0, 2) == 0) begin
            rx_valid     = 1;
            parity_error = ($urandom_range(0, 3) == 0);
        end
        if (mode != 2) alu_out_valid = ($urandom_range(0, 3) == 0);
        if (mode != 1) rf_rd_valid = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        int n = 0;
        while (txq.size() != 0) begin
            if (n >= 100) timeout("tx_drain");
            n++;
            wait_junk(3);
        end
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx_valid) return;
        end
        timeout("wait_tx");
    endtask

    task automatic idle_gap();
        int n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i < n; i++) begin
            step();
            rf_rd_valid   = ($urandom_range(0, 3) == 0);
            alu_out_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                rx_valid = 1;
                rx_data  = junk_byte();
                if ($urandom_range(0, 7) == 0) begin
                    framing_error = 1;
`ifdef CMD_ERR_DROP_EN
                    push(cyc + 1, EV_ERR, 0, 0);
`endif
                end
            end
        end
    endtask

    task automatic frame_wr(input logic [7:0] a, input logic [7:0] d, input int em);
        bit ab;
        send_byte(8'hAA, em, ab); if (ab) return;
        send_byte(a, em, ab);     if (ab) return;
        send_byte(d, em, ab);     if (ab) return;
        push(cyc + 1, EV_WR, int'(a[3:0]), int'(d));
    endtask

    task automatic frame_rd(input logic [7:0] a, input logic [7:0] d, input int em);
        bit ab;
        send_byte(8'hBB, em, ab); if (ab) return;
        send_byte(a, em, ab);     if (ab) return;
        push(cyc + 1, EV_RD, int'(a[3:0]), 0);
        repeat ($urandom_range(0, 4)) wait_junk(1);
        wait_junk(1);
        rf_rd_valid = 1;
        rf_rd_data  = d;
        txq.push_back(d);
        drain();
    endtask

    task automatic frame_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input logic [15:0] res, input int em);
        bit ab;
        if (ops) begin
            send_byte(8'hCC, em, ab); if (ab) return;
            send_byte(a, em, ab);     if (ab) return;
            push(cyc + 1, EV_WR, 0, int'(a));
            send_byte(b, em, ab);     if (ab) return;
            push(cyc + 1, EV_WR, 1, int'(b));
        end else begin
            send_byte(8'hDD, em, ab); if (ab) return;
        end
        push(cyc + 1, EV_GON, 0, 0);
        gate_on = 1;
        send_byte(f, em, ab); if (ab) return;
        push(cyc + 1, EV_ALU, int'(f[3:0]), 0);
        repeat ($urandom_range(0, 4)) wait_junk(2);
        wait_junk(2);
        alu_out_valid = 1;
        alu_out       = res;
        push(cyc + 1, EV_GOFF, 0, 0);
        gate_on = 0;
        txq.push_back(res[7:0]);
        txq.push_back(res[15:8]);
        drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, rf_wr_en, 0);
        chk({tag, "_rd_en"}, rf_rd_en, 0);
        chk({tag, "_addr"}, rf_addr, 0);
        chk({tag, "_wdata"}, rf_wr_data, 0);
        chk({tag, "_alu_en"}, alu_en, 0);
        chk({tag, "_fun"}, alu_fun, 0);
        chk({tag, "_gate"}, clk_gate_en, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_cmd_err"}, cmd_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        bit ab;
        #2 rst = 0;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1;

        // Write AA,05,3C
        frame_wr(8'h05, 8'h3C, 0);
        step();
        chk("lit_wr_en", rf_wr_en, 1);
        chk("lit_wr_addr", rf_addr, 4'h5);
        chk("lit_wr_data", rf_wr_data, 8'h3C);
        step();
        chk("lit_wr_en_once", rf_wr_en, 0);

        // Read BB,05 -> 0x3C
        send_byte(8'hBB, 0, ab);
        send_byte(8'h05, 0, ab);
        push(cyc + 1, EV_RD, 5, 0);
        step();
        chk("lit_rd_en", rf_rd_en, 1);
        chk("lit_rd_addr", rf_addr, 4'h5);
        rf_rd_valid = 1;
        rf_rd_data  = 8'h3C;
        txq.push_back(8'h3C);
        wait_tx();
        chk("lit_rd_tx", tx_data, 8'h3C);
        step();
        chk("lit_rd_tx_once", tx_valid, 0);

        // ALU CC,0A,03,00 -> 0x001E
        send_byte(8'hCC, 0, ab);
        send_byte(8'h0A, 0, ab);
        push(cyc + 1, EV_WR, 0, 8'h0A);
        send_byte(8'h03, 0, ab);
        push(cyc + 1, EV_WR, 1, 8'h03);
        push(cyc + 1, EV_GON, 0, 0);
        chk("lit_alu_wa", {rf_wr_en, 4'(rf_addr), rf_wr_data}, {1'b1, 4'h0, 8'h0A});
        send_byte(8'h00, 0, ab);
        push(cyc + 1, EV_ALU, 0, 0);
        chk("lit_alu_wb", {rf_wr_en, 4'(rf_addr), rf_wr_data}, {1'b1, 4'h1, 8'h03});
        chk("lit_gate_fun", clk_gate_en, 1);
        step();
        chk("lit_alu_en", alu_en, 1);
        chk("lit_alu_fun", alu_fun, 4'h0);
        chk("lit_gate_wait", clk_gate_en, 1);
        alu_out_valid = 1;
        alu_out       = 16'h001E;
        push(cyc + 1, EV_GOFF, 0, 0);
        txq.push_back(8'h1E);
        txq.push_back(8'h00);
        wait_tx();
        chk("lit_alu_tx0", tx_data, 8'h1E);
        chk("lit_gate_off", clk_gate_en, 0);
        step();
        chk("lit_alu_tx1", {tx_valid, tx_data}, {1'b1, 8'h00});

        // Backpressure DD,01 -> 0xABCD with FIFO full for 5 cycles
        send_byte(8'hDD, 0, ab);
        push(cyc + 1, EV_GON, 0, 0);
        send_byte(8'h01, 0, ab);
        push(cyc + 1, EV_ALU, 1, 0);
        step();
        chk("lit_dd_fun", alu_fun, 4'h1);
        alu_out_valid = 1;
        alu_out       = 16'hABCD;
        tx_fifo_full  = 1;
        push(cyc + 1, EV_GOFF, 0, 0);
        txq.push_back(8'hCD);
        txq.push_back(8'hAB);
        repeat (4) begin
            step();
            tx_fifo_full = 1;
            chk("lit_bp_hold", tx_valid, 0);
        end
        step();
        chk("lit_bp_hold_last", tx_valid, 0);
        wait_tx();
        chk("lit_bp_tx0", tx_data, 8'hCD);
        step();
        chk("lit_bp_tx1", {tx_valid, tx_data}, {1'b1, 8'hAB});
        step();
        chk("lit_bp_no_dup", tx_valid, 0);

        // Error on address byte
        send_byte(8'hAA, 0, ab);
        send_byte(8'h05, 2, ab);
        send_byte(8'h3C, 0, ab);
`ifdef CMD_ERR_DROP_EN
        chk("lit_err_pulse", cmd_err, 1);
        step();
        chk("lit_err_no_wr", rf_wr_en, 0);
`else
        push(cyc + 1, EV_WR, 5, 8'h3C);
        chk("lit_err_ignored", cmd_err, 0);
        step();
        chk("lit_err_wr", {rf_wr_en, 4'(rf_addr), rf_wr_data}, {1'b1, 4'h5, 8'h3C});
`endif

        // Reset mid-frame
        send_byte(8'hAA, 0, ab);
        send_byte(8'h05, 0, ab);
        step();
        rst = 0;
        #1;
        chk_all_zero("midrst");
        evq.delete(); txq.delete();
        gate_on = 0; exp_gate = 0;
        h_addr = '0; h_wdata = '0; h_fun = '0; h_tx = '0;
        repeat (2) step();
        rst = 1;
        frame_wr(8'h02, 8'h11, 0);
        step();
        chk("lit_postrst_wr", {rf_wr_en, 4'(rf_addr), rf_wr_data}, {1'b1, 4'h2, 8'h11});

        // Randomized frames with back-to-back arrival, noise and backpressure
        rand_full = 1;
        for (int i = 0; i < 150; i++) begin
            idle_gap();
            case ($urandom_range(0, 3))
                0: frame_wr(8'($urandom), 8'($urandom), 1);
                1: frame_rd(8'($urandom), 8'($urandom), 1);
                2: frame_alu(1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 1);
                default: frame_alu(0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), 1);
            endcase
        end
        rand_full = 0;
        repeat (5) step();
        chk("events_drained", evq.size(), 0);
        chk("tx_drained", txq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
